// File: rtl/vga_pattern_gen_pkg.sv
// Shared definitions for the 800x600@60 VGA path: timing, palette, pattern modes.
package vga_pkg;

  // 800x600@60 Hz timing, 40 MHz pixel clock
  localparam int H_SYNC  = 128;
  localparam int H_BP    = 88;
  localparam int H_ACT   = 800;
  localparam int H_FP    = 40;
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;  // 1056
  localparam int V_SYNC  = 4;
  localparam int V_BP    = 23;
  localparam int V_ACT   = 600;
  localparam int V_FP    = 1;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;  // 628

  localparam int H_ACT_START = H_SYNC + H_BP;  // 216
  localparam int V_ACT_START = V_SYNC + V_BP;  // 27

  // Bouncing box geometry: top-left corner ranges keep the whole box on screen
  localparam int BOX    = 64;
  localparam int BX_MAX = H_ACT - BOX;  // 736
  localparam int BY_MAX = V_ACT - BOX;  // 536

  // Frames shown per solid colour before moving to the next palette entry
  localparam int FRAMES_PER_COLOUR = 60;

  // RGB565 colours
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  // Colour-bar order, also used as the solid-colour cycle
  function automatic logic [15:0] palette(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

  // One bounce step on a 0..lim axis; returns {new_dir, new_pos}, dir 1 = increasing.
  // At an edge the direction flips and the position moves one step back inward.
  function automatic logic [10:0] bounce_step(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] lim);
    logic [10:0] r;
    if (dir) begin
      r = (pos == lim) ? {1'b0, pos - 10'd1} : {1'b1, pos + 10'd1};
    end else begin
      r = (pos == 10'd0) ? {1'b1, 10'd1} : {1'b0, pos - 10'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button level plus a one-cycle rising-edge pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  // r_sync[0..1] resynchronise, r_sync[2] remembers the previous synchronised level
  logic [2:0] r_sync;

  // Shift the button level through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], i_btn};
    end
  end

  assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: 2-stage pixel pipeline behind vga_sync, per-frame animation state
// and a button-stepped pattern selector that only switches at frame start.
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [10:0] c1,
  input  logic [10:0] c2,
  input  logic        mode_btn,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de,
  output logic [15:0] rgb,
  output logic [1:0]  mode
);

  localparam logic [10:0] C1_LO = 11'(H_ACT_START);
  localparam logic [10:0] C1_HI = 11'(H_ACT_START + H_ACT);
  localparam logic [10:0] C2_LO = 11'(V_ACT_START);
  localparam logic [10:0] C2_HI = 11'(V_ACT_START + V_ACT);
  localparam logic [9:0]  X_OFF = 10'(H_ACT_START);
  localparam logic [9:0]  Y_OFF = 10'(V_ACT_START);

  // Stage 1
  logic       r_act1, r_hs1, r_vs1;
  logic [9:0] r_x1, r_y1;
  // Stage 2 (outputs)
  logic        r_de, r_hs2, r_vs2;
  logic [15:0] r_rgb;
  // Per-frame state
  logic [9:0] r_bx, r_by;
  logic       r_dx, r_dy;
  logic [5:0] r_fcnt;
  logic [2:0] r_sidx;
  logic       r_pending;
  mode_e      r_mode;

  logic        w_act, w_fs, w_rise, w_in_box;
  logic [6:0]  w_therm;
  logic [2:0]  w_bar;
  logic [15:0] w_color;
  logic [10:0] w_bx_step, w_by_step;

  btn_edge_sync u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .i_btn (mode_btn),
    .o_rise(w_rise)
  );

  assign w_act = (c1 >= C1_LO) && (c1 < C1_HI) && (c2 >= C2_LO) && (c2 < C2_HI);
  assign w_fs  = (c1 == 11'd0) && (c2 == 11'd0);

  // Stage 1: active flag, pixel coordinates, first sync delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act1 <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_x1   <= '0;
      r_y1   <= '0;
    end else begin
      r_act1 <= w_act;
      r_hs1  <= hsync;
      r_vs1  <= vsync;
      r_x1   <= c1[9:0] - X_OFF;
      r_y1   <= c2[9:0] - Y_OFF;
    end
  end

  // Bar boundaries every 100 pixels as a thermometer code
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
      assign w_therm[gi-1] = (r_x1 >= 10'(gi * 100));
    end
  endgenerate

  // Thermometer to bar index, plus per-mode colour selection
  always_comb begin
    w_bar = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (w_therm[i]) w_bar = 3'(i + 1);
    end
    w_in_box = (r_x1 >= r_bx) && (r_x1 < r_bx + 10'(BOX)) &&
               (r_y1 >= r_by) && (r_y1 < r_by + 10'(BOX));
    case (r_mode)
      MODE_BARS:  w_color = palette(w_bar);
      MODE_CHECK: w_color = (r_x1[5] ^ r_y1[5]) ? RGB_WHITE : RGB_BLACK;
      MODE_BOX:   w_color = w_in_box ? RGB_RED : RGB_BLUE;
      default:    w_color = palette(r_sidx);
    endcase
  end

  // Stage 2: blanked pixel, data enable and second sync delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de  <= 1'b0;
      r_hs2 <= 1'b0;
      r_vs2 <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_de  <= r_act1;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_rgb <= r_act1 ? w_color : RGB_BLACK;
    end
  end

  assign w_bx_step = bounce_step(r_bx, r_dx, 10'(BX_MAX));
  assign w_by_step = bounce_step(r_by, r_dy, 10'(BY_MAX));

  // Animation state advances once per frame, in every mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bx   <= '0;
      r_by   <= '0;
      r_dx   <= 1'b1;
      r_dy   <= 1'b1;
      r_fcnt <= '0;
      r_sidx <= '0;
    end else if (w_fs) begin
      {r_dx, r_bx} <= w_bx_step;
      {r_dy, r_by} <= w_by_step;
      if (r_fcnt == 6'(FRAMES_PER_COLOUR - 1)) begin
        r_fcnt <= '0;
        r_sidx <= r_sidx + 3'd1;
      end else begin
        r_fcnt <= r_fcnt + 6'd1;
      end
    end
  end

  // Mode FSM: button edges are collected per frame and applied as one step at frame start;
  // an edge arriving in the frame-start cycle itself carries over to the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= MODE_BARS;
      r_pending <= 1'b0;
    end else if (w_fs) begin
      if (r_pending) r_mode <= mode_e'(r_mode + 2'd1);
      r_pending <= w_rise;
    end else if (w_rise) begin
      r_pending <= 1'b1;
    end
  end

  assign hsync_o = r_hs2;
  assign vsync_o = r_vs2;
  assign de      = r_de;
  assign rgb     = r_rgb;
  assign mode    = r_mode;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: table-driven pixel checks plus frame/mode sequences.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b0, vsync = 1'b0;
  logic [10:0] c1 = 11'd0, c2 = 11'd0;
  logic        mode_btn = 1'b0;
  logic        hsync_o, vsync_o, de;
  logic [15:0] rgb;
  logic [1:0]  d_mode;

  int n_checks = 0;
  int n_fail   = 0;
  int fs_cnt   = 0;

  typedef struct {
    logic [10:0] c1;
    logic [10:0] c2;
    logic        de;
    logic [15:0] rgb;
  } vec_t;

  vec_t bars[16];

  vga_pattern_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hsync   (hsync),
    .vsync   (vsync),
    .c1      (c1),
    .c2      (c2),
    .mode_btn(mode_btn),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .de      (de),
    .rgb     (rgb),
    .mode    (d_mode)
  );

  always #12.5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int x1, input int x2);
    c1    = 11'(x1);
    c2    = 11'(x2);
    hsync = (x1 < 128);
    vsync = (x2 < 4);
  endtask

  task automatic frame_start();
    set_in(0, 0);
    tick();
    fs_cnt++;
    set_in(500, 300);
    tick();
  endtask

  task automatic pulse();
    mode_btn = 1'b1;
    repeat (4) tick();
    mode_btn = 1'b0;
    repeat (4) tick();
  endtask

  task automatic step_mode();
    pulse();
    frame_start();
  endtask

  task automatic check_px(input string name, input int x, input int y, input logic [15:0] exp);
    set_in(216 + x, 27 + y);
    tick();
    tick();
    chk({name, " de"}, {31'd0, de}, 32'd1);
    chk({name, " rgb"}, {16'd0, rgb}, {16'd0, exp});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    fs_cnt = 0;
    rst_n = 1'b1;
  endtask

  logic hs_h[24], vs_h[24];
  int   c1_h[24];

  initial begin
    bars[0]  = '{11'd216,  11'd27,  1'b1, 16'hFFFF};
    bars[1]  = '{11'd315,  11'd27,  1'b1, 16'hFFFF};
    bars[2]  = '{11'd316,  11'd27,  1'b1, 16'hFFE0};
    bars[3]  = '{11'd415,  11'd27,  1'b1, 16'hFFE0};
    bars[4]  = '{11'd416,  11'd27,  1'b1, 16'h07FF};
    bars[5]  = '{11'd516,  11'd100, 1'b1, 16'h07E0};
    bars[6]  = '{11'd616,  11'd200, 1'b1, 16'hF81F};
    bars[7]  = '{11'd716,  11'd300, 1'b1, 16'hF800};
    bars[8]  = '{11'd816,  11'd400, 1'b1, 16'h001F};
    bars[9]  = '{11'd916,  11'd27,  1'b1, 16'h0000};
    bars[10] = '{11'd1015, 11'd27,  1'b1, 16'h0000};
    bars[11] = '{11'd1016, 11'd27,  1'b0, 16'h0000};
    bars[12] = '{11'd215,  11'd27,  1'b0, 16'h0000};
    bars[13] = '{11'd216,  11'd26,  1'b0, 16'h0000};
    bars[14] = '{11'd216,  11'd626, 1'b1, 16'hFFFF};
    bars[15] = '{11'd216,  11'd627, 1'b0, 16'h0000};

    // Reset: 1 us with live sync inputs, all outputs must stay low
    set_in(50, 2);
    repeat (40) tick();
    chk("reset rgb", {16'd0, rgb}, 32'd0);
    chk("reset de", {31'd0, de}, 32'd0);
    chk("reset hsync_o", {31'd0, hsync_o}, 32'd0);
    chk("reset vsync_o", {31'd0, vsync_o}, 32'd0);
    chk("reset mode", {30'd0, d_mode}, 32'd0);
    rst_n = 1'b1;

    // Latency: outputs follow the inputs presented two edges earlier
    for (int i = 0; i < 24; i++) begin
      c1 = 11'(206 + i);
      c2 = 11'd27;
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      hs_h[i] = hsync;
      vs_h[i] = vsync;
      c1_h[i] = 206 + i;
      tick();
      if (i >= 1) begin
        chk($sformatf("lat hsync_o c1=%0d", c1_h[i-1]), {31'd0, hsync_o}, {31'd0, hs_h[i-1]});
        chk($sformatf("lat vsync_o c1=%0d", c1_h[i-1]), {31'd0, vsync_o}, {31'd0, vs_h[i-1]});
        chk($sformatf("lat de c1=%0d", c1_h[i-1]), {31'd0, de}, (c1_h[i-1] >= 216) ? 32'd1 : 32'd0);
        chk($sformatf("lat rgb c1=%0d", c1_h[i-1]), {16'd0, rgb},
            (c1_h[i-1] >= 216) ? 32'h0000FFFF : 32'd0);
      end
    end

    // Colour bars and active-window edges
    for (int i = 0; i < 16; i++) begin
      set_in(int'(bars[i].c1), int'(bars[i].c2));
      tick();
      tick();
      chk($sformatf("bars de c1=%0d c2=%0d", bars[i].c1, bars[i].c2), {31'd0, de}, {31'd0, bars[i].de});
      chk($sformatf("bars rgb c1=%0d c2=%0d", bars[i].c1, bars[i].c2), {16'd0, rgb}, {16'd0, bars[i].rgb});
    end

    // Checkerboard: mid-frame press only takes effect at frame start
    set_in(500, 300);
    pulse();
    chk("mode before fs", {30'd0, d_mode}, 32'd0);
    frame_start();
    chk("mode after fs", {30'd0, d_mode}, 32'd1);
    check_px("chk (0,0)", 0, 0, 16'h0000);
    check_px("chk (32,0)", 32, 0, 16'hFFFF);
    check_px("chk (32,32)", 32, 32, 16'h0000);
    check_px("chk (0,32)", 0, 32, 16'hFFFF);

    // Asynchronous reset mid-frame clears outputs without a clock edge
    #5;
    rst_n = 1'b0;
    #1;
    chk("async rst rgb", {16'd0, rgb}, 32'd0);
    chk("async rst de", {31'd0, de}, 32'd0);
    chk("async rst mode", {30'd0, d_mode}, 32'd0);
    do_reset();

    // Bouncing box
    step_mode();
    step_mode();
    chk("box mode", {30'd0, d_mode}, 32'd2);
    check_px("box f2 (2,2)", 2, 2, 16'hF800);
    check_px("box f2 (1,2)", 1, 2, 16'h001F);
    check_px("box f2 (2,1)", 2, 1, 16'h001F);
    check_px("box f2 (65,65)", 65, 65, 16'hF800);
    check_px("box f2 (66,65)", 66, 65, 16'h001F);
    while (fs_cnt < 536) frame_start();
    check_px("box f536 (536,536)", 536, 536, 16'hF800);
    check_px("box f536 (536,535)", 536, 535, 16'h001F);
    check_px("box f536 (599,599)", 599, 599, 16'hF800);
    check_px("box f536 (600,599)", 600, 599, 16'h001F);
    frame_start();
    check_px("box f537 (537,535)", 537, 535, 16'hF800);
    check_px("box f537 (537,599)", 537, 599, 16'h001F);
    while (fs_cnt < 736) frame_start();
    check_px("box f736 (736,336)", 736, 336, 16'hF800);
    check_px("box f736 (735,336)", 735, 336, 16'h001F);
    check_px("box f736 (799,399)", 799, 399, 16'hF800);
    frame_start();
    check_px("box f737 (735,335)", 735, 335, 16'hF800);
    check_px("box f737 (734,335)", 734, 335, 16'h001F);
    check_px("box f737 (799,335)", 799, 335, 16'h001F);

    // Solid colour cycling
    do_reset();
    step_mode();
    step_mode();
    step_mode();
    chk("solid mode", {30'd0, d_mode}, 32'd3);
    check_px("solid f3 (0,0)", 0, 0, 16'hFFFF);
    check_px("solid f3 (799,599)", 799, 599, 16'hFFFF);
    set_in(100, 100);
    tick();
    tick();
    chk("solid blank rgb", {16'd0, rgb}, 32'd0);
    chk("solid blank de", {31'd0, de}, 32'd0);
    while (fs_cnt < 59) frame_start();
    check_px("solid f59", 400, 300, 16'hFFFF);
    frame_start();
    check_px("solid f60 (0,0)", 0, 0, 16'hFFE0);
    check_px("solid f60 (799,599)", 799, 599, 16'hFFE0);
    while (fs_cnt < 119) frame_start();
    check_px("solid f119", 400, 300, 16'hFFE0);
    frame_start();
    check_px("solid f120", 400, 300, 16'h07FF);

    // Mode 3 wraps to mode 0
    step_mode();
    chk("wrap mode", {30'd0, d_mode}, 32'd0);
    check_px("wrap bars (0,0)", 0, 0, 16'hFFFF);

    // Three presses in one frame give one step
    set_in(500, 300);
    pulse();
    pulse();
    pulse();
    chk("3 pulses pre-fs", {30'd0, d_mode}, 32'd0);
    frame_start();
    chk("3 pulses fs1", {30'd0, d_mode}, 32'd1);
    frame_start();
    chk("3 pulses fs2", {30'd0, d_mode}, 32'd1);

    // Edge landing in the frame-start cycle is deferred one frame
    mode_btn = 1'b1;
    tick();
    tick();
    set_in(0, 0);
    tick();
    fs_cnt++;
    set_in(500, 300);
    chk("fs-edge same fs", {30'd0, d_mode}, 32'd1);
    mode_btn = 1'b0;
    repeat (4) tick();
    chk("fs-edge held", {30'd0, d_mode}, 32'd1);
    frame_start();
    chk("fs-edge next fs", {30'd0, d_mode}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
